random_producer: RTL and testbench

Traffic source that generates pseudo-random SIZE-bit data words and delivers them over a 4-phase (return-to-zero) req/ack handshake. It sits directly upstream of the random consumer endpoint and also drives router input ports in NoC test benches. Both the data and the inter-packet gap come from a 16-bit LFSR, so a given SEED always produces the same traffic. A packet budget and a done flag let benches end a run cleanly.

---
 rtl/random_producer_pkg.sv | 24 ++
 rtl/random_producer_lfsr16.sv | 27 ++
 rtl/random_producer.sv | 155 +++++++++++++++
 tb/tb_random_producer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/random_producer_pkg.sv
// Shared constants, FSM encoding and LFSR helpers for the random traffic producer.
// 4-phase (return-to-zero) handshake: req rises with data, ack rises, req falls, ack falls.
package random_producer_pkg;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_REQ  = 2'd1,
    ST_RTZ  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Galois right-shift step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // An all-zero seed would lock the LFSR, so it is mapped to 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/random_producer_lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable by routers and benches.
module lfsr16
  import random_producer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  localparam logic [15:0] SEED_EFF = seed_fix(SEED);

  logic [15:0] state_r;

  // Advance once per clock edge whenever out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= SEED_EFF;
    end else begin
      state_r <= lfsr_next(state_r);
    end
  end

  assign state = state_r;

endmodule

// File: rtl/random_producer.sv
// Pseudo-random traffic source: LFSR-derived data and gaps, delivered over a 4-phase req/ack handshake.
module random_producer
  import random_producer_pkg::*;
#(
  parameter int          ID    = 0,
  parameter int          SIZE  = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          GAP_W = 4,
  parameter int          COUNT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            ack,
  output logic            req,
  output logic [SIZE-1:0] data,
  output logic [15:0]     sent_count,
  output logic            done
);

  if (SIZE < 1 || SIZE > 16 || GAP_W < 1 || GAP_W > 16 || ID < 0) begin : g_bad_param
    $error("random_producer: illegal parameter value");
  end

  localparam logic        COUNT_EN = (COUNT != 0);
  localparam logic [15:0] COUNT_W  = 16'(COUNT);

  logic [15:0]      lfsr_s;
  logic             unused_lfsr_s;
  state_t           state_r;
  state_t           next_state_s;
  logic             req_r;
  logic             req_s;
  logic [SIZE-1:0]  data_r;
  logic [SIZE-1:0]  data_s;
  logic [15:0]      sent_count_r;
  logic [15:0]      sent_count_s;
  logic             done_r;
  logic             done_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [GAP_W-1:0] gap_cnt_s;
  logic             gap_zero_s;
  logic             count_hit_s;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s;
  assign gap_zero_s    = (gap_cnt_r == {GAP_W{1'b0}});
  assign count_hit_s   = COUNT_EN && (sent_count_r == COUNT_W);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_GAP;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a stray ack in GAP blocks the launch until it clears.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_GAP: begin
        if (en && gap_zero_s && !ack) next_state_s = ST_REQ;
        else                          next_state_s = ST_GAP;
      end
      ST_REQ: begin
        if (ack) next_state_s = ST_RTZ;
        else     next_state_s = ST_REQ;
      end
      ST_RTZ: begin
        if (ack)              next_state_s = ST_RTZ;
        else if (count_hit_s) next_state_s = ST_DONE;
        else                  next_state_s = ST_GAP;
      end
      ST_DONE: next_state_s = ST_DONE;
      default: next_state_s = ST_GAP;
    endcase
  end

  // Next values for the registered outputs and the gap counter.
  always_comb begin
    req_s        = req_r;
    data_s       = data_r;
    sent_count_s = sent_count_r;
    done_s       = done_r;
    gap_cnt_s    = gap_cnt_r;
    case (state_r)
      ST_GAP: begin
        if (!en) begin
          gap_cnt_s = gap_cnt_r;
        end else if (!gap_zero_s) begin
          gap_cnt_s = gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
        end else if (!ack) begin
          req_s  = 1'b1;
          data_s = lfsr_s[SIZE-1:0];
        end else begin
          req_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (ack) begin
          req_s = 1'b0;
          if (sent_count_r != 16'hFFFF) sent_count_s = sent_count_r + 16'd1;
          else                          sent_count_s = sent_count_r;
        end else begin
          req_s = 1'b1;
        end
      end
      ST_RTZ: begin
        if (!ack) begin
          gap_cnt_s = lfsr_s[15 -: GAP_W];
          done_s    = count_hit_s;
        end else begin
          gap_cnt_s = gap_cnt_r;
        end
      end
      ST_DONE: begin
        req_s  = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  // Output and counter registers; reset drops req asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_r        <= 1'b0;
      data_r       <= {SIZE{1'b0}};
      sent_count_r <= 16'h0000;
      done_r       <= 1'b0;
      gap_cnt_r    <= {GAP_W{1'b0}};
    end else begin
      req_r        <= req_s;
      data_r       <= data_s;
      sent_count_r <= sent_count_s;
      done_r       <= done_s;
      gap_cnt_r    <= gap_cnt_s;
    end
  end

  assign req        = req_r;
  assign data       = data_r;
  assign sent_count = sent_count_r;
  assign done       = done_r;

endmodule

// File: tb/tb_random_producer.sv
// Directed, table-driven bench for random_producer with a registered (ack <= req) responder.
module tb_random_producer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        ack;
  logic        req;
  logic [7:0]  data;
  logic [15:0] sent_count;
  logic        done;
  logic        ack_inf;
  logic        req_inf;
  logic [7:0]  data_inf;
  logic [15:0] sent_inf;
  logic        done_inf;
  logic        auto_ack;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        exp_req;
    logic [7:0]  exp_data;
    logic [15:0] exp_sent;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  random_producer #(.ID(0), .SIZE(8), .SEED(16'hACE1), .GAP_W(4), .COUNT(3)) u_dut (
    .clk(clk), .reset(reset), .en(en), .ack(ack),
    .req(req), .data(data), .sent_count(sent_count), .done(done)
  );

  random_producer #(.ID(1), .SIZE(8), .SEED(16'hACE1), .GAP_W(4), .COUNT(0)) u_inf (
    .clk(clk), .reset(reset), .en(en), .ack(ack_inf),
    .req(req_inf), .data(data_inf), .sent_count(sent_inf), .done(done_inf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock edge; responders return the req value seen before the edge.
  task automatic tick();
    logic r;
    logic ri;
    r  = req;
    ri = req_inf;
    @(posedge clk);
    #1;
    if (auto_ack) ack = r;
    ack_inf = ri;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    ack     = 1'b0;
    ack_inf = 1'b0;
    #1;
    release_reset();
  endtask

  task automatic add_vec(input int n, input logic r, input logic [7:0] d, input logic [15:0] s, input logic dn);
    for (int i = 0; i < n; i++) vecs.push_back('{r, d, s, dn});
  endtask

  logic found;

  initial begin
    // Edges 1..19 after reset release with en=1 and a registered responder.
    add_vec(2, 1'b1, 8'hE1, 16'd0, 1'b0);
    add_vec(4, 1'b0, 8'hE1, 16'd1, 1'b0);
    add_vec(2, 1'b1, 8'h13, 16'd1, 1'b0);
    add_vec(6, 1'b0, 8'h13, 16'd2, 1'b0);
    add_vec(2, 1'b1, 8'h8B, 16'd2, 1'b0);
    add_vec(2, 1'b0, 8'h8B, 16'd3, 1'b0);
    add_vec(1, 1'b0, 8'h8B, 16'd3, 1'b1);

    auto_ack = 1'b1;
    en       = 1'b1;
    reset    = 1'b1;
    ack      = 1'b0;
    ack_inf  = 1'b0;
    #2;
    chk("reset state", {6'd0, req, data, sent_count, done}, 32'd0);
    release_reset();

    // Tests 1-3: launch timing, LFSR data, gap, COUNT=3 termination.
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      chk($sformatf("vec edge%0d", i + 1),
          {6'd0, req, data, sent_count, done},
          {6'd0, vecs[i].exp_req, vecs[i].exp_data, vecs[i].exp_sent, vecs[i].exp_done});
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("done hold", {13'd0, req, sent_count, done}, {13'd0, 1'b0, 16'd3, 1'b1});
    end
    n_vec++;
    if (!(sent_inf > 16'd3 && done_inf == 1'b0)) begin
      n_bad++;
      $display("FAIL unlimited count: got sent=%0d done=%b, expected sent>3 done=0", sent_inf, done_inf);
    end

    // Test 4: responder stalls ack for 20 cycles.
    auto_ack = 1'b0;
    apply_reset();
    tick();
    chk("stall launch", {7'd0, req, data, sent_count}, {7'd0, 1'b1, 8'hE1, 16'd0});
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall hold", {7'd0, req, data, sent_count}, {7'd0, 1'b1, 8'hE1, 16'd0});
    end
    ack = 1'b1;
    tick();
    chk("stall ack", {15'd0, req, sent_count}, {15'd0, 1'b0, 16'd1});
    ack = 1'b0;
    tick();
    auto_ack = 1'b1;

    // Test 5: en dropped mid-handshake.
    apply_reset();
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("en drop complete", {15'd0, req, sent_count}, {15'd0, 1'b0, 16'd1});
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("en low idle", {31'd0, req}, 32'd0);
    end
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 17 && !found; i++) begin
      tick();
      if (req) found = 1'b1;
    end
    chk("en relaunch", {31'd0, found}, 32'd1);
    chk("en relaunch data", {24'd0, data}, {24'd0, 8'h62});

    // Test 6: reset while the second packet is in REQ.
    apply_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("pre-reset req", {7'd0, req, data, sent_count}, {7'd0, 1'b1, 8'h13, 16'd1});
    reset   = 1'b1;
    ack     = 1'b0;
    ack_inf = 1'b0;
    #1;
    chk("async reset", {14'd0, req, sent_count, done}, 32'd0);
    release_reset();
    tick();
    chk("post-reset first", {23'd0, req, data}, {23'd0, 1'b1, 8'hE1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
